// File: rtl/craft_pkg.sv
// craft_pkg -- shared constants and helpers for the CRAFT decryption core.
//
// Nibble ordering: nibble 0 is bits [63:60], nibble 15 is bits [3:0].
// Contents: FSM state enum, S-box, PN permutation and its inverse, tweak
// permutation Q, the 32-entry round-constant table, and the per-layer helper
// functions (SubCells, PN, PN inverse, Q, MixColumns, AddRoundConstant).
package craft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIBBLES = 16;

  // First inverse round applied after the accept step, and the last one.
  localparam logic [4:0] ROUND_FIRST = 5'd30;
  localparam logic [4:0] ROUND_LAST  = 5'd0;

  // S-box is an involution, so the same table serves both directions.
  localparam logic [3:0] SBOX [NIBBLES] = '{
    4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
    4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
  };

  // PN: out[P(i)] = in[i].
  localparam logic [3:0] PERM_P [NIBBLES] = '{
    4'd15, 4'd12, 4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd11,
    4'd6,  4'd5,  4'd4,  4'd7,  4'd1,  4'd2, 4'd3, 4'd0
  };

  // Inverse of P (P happens to be its own inverse; kept explicit for clarity).
  localparam logic [3:0] PERM_PINV [NIBBLES] = '{
    4'd15, 4'd12, 4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd11,
    4'd6,  4'd5,  4'd4,  4'd7,  4'd1,  4'd2, 4'd3, 4'd0
  };

  // Tweak permutation: Q(T)[i] = T[Q(i)].
  localparam logic [3:0] PERM_Q [NIBBLES] = '{
    4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9, 4'd2,
    4'd11, 4'd3,  4'd7,  4'd4, 4'd6,  4'd0, 4'd1, 4'd13
  };

  // RC_i = {a_i, 1'b0, b_i}, indexed by round number.
  localparam logic [7:0] RC_TABLE [32] = '{
    8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hC7, 8'h63, 8'hB1,
    8'h54, 8'hA2, 8'hD5, 8'hE6, 8'hF7, 8'h73, 8'h31, 8'h14,
    8'h82, 8'h45, 8'h26, 8'h97, 8'hC3, 8'h61, 8'hB4, 8'h52,
    8'hA5, 8'hD6, 8'hE7, 8'hF3, 8'h71, 8'h34, 8'h12, 8'h85
  };

  function automatic logic [3:0] get_nib(input logic [63:0] x, input int i);
    return x[63 - 4*i -: 4];
  endfunction

  function automatic logic [63:0] sub_cells(input logic [63:0] x);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      res[63 - 4*i -: 4] = SBOX[get_nib(x, i)];
    end
    return res;
  endfunction

  function automatic logic [63:0] pn(input logic [63:0] x);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      res[63 - 4*int'(PERM_P[i]) -: 4] = get_nib(x, i);
    end
    return res;
  endfunction

  // Undo PN: the nibble at position j returns to position Pinv(j).
  function automatic logic [63:0] pn_inv(input logic [63:0] x);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      res[63 - 4*int'(PERM_PINV[i]) -: 4] = get_nib(x, i);
    end
    return res;
  endfunction

  function automatic logic [63:0] q_perm(input logic [63:0] x);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      res[63 - 4*i -: 4] = get_nib(x, int'(PERM_Q[i]));
    end
    return res;
  endfunction

  // Rows of four nibbles; R0 ^= R2 ^ R3, R1 ^= R3. Self-inverse.
  function automatic logic [63:0] mix_columns(input logic [63:0] x);
    logic [15:0] r0, r1, r2, r3;
    r0 = x[63:48];
    r1 = x[47:32];
    r2 = x[31:16];
    r3 = x[15:0];
    return {r0 ^ r2 ^ r3, r1 ^ r3, r2, r3};
  endfunction

  // rc[7:4] lands in nibble 4, rc[3:0] in nibble 5 (bits [47:40]).
  function automatic logic [63:0] add_rc(input logic [63:0] x, input logic [7:0] rc);
    return x ^ {16'h0000, rc, 40'h00_0000_0000};
  endfunction

  // Step both constant LFSRs one round backwards.
  function automatic logic [7:0] rc_back(input logic [7:0] rc);
    logic [3:0] a;
    logic [2:0] b;
    a = rc[7:4];
    b = rc[2:0];
    return {a[2:0], a[3] ^ a[0], 1'b0, b[1:0], b[2] ^ b[0]};
  endfunction

endpackage

// File: rtl/craft_decrypt_inv_round.sv
// craft_inv_round -- one combinational CRAFT inverse round.
//
// dout = MC( PN^-1( S(din) ) ^ tk ^ ARC(rc) )
//
// Ports:
//   din   in  64  round input state
//   tk    in  64  tweakey for this round
//   rc    in  8   round constant {a, 0, b}
//   dout  out 64  round output state
module craft_inv_round
  import craft_pkg::*;
(
  input  logic [63:0] din,
  input  logic [63:0] tk,
  input  logic [7:0]  rc,
  output logic [63:0] dout
);

  logic [63:0] unsub;
  logic [63:0] unperm;
  logic [63:0] keyed;

  assign unsub  = sub_cells(din);
  assign unperm = pn_inv(unsub);
  assign keyed  = add_rc(unperm ^ tk, rc);
  assign dout   = mix_columns(keyed);

endmodule

// File: rtl/craft_decrypt.sv
// craft_decrypt -- iterative CRAFT block decryption, one inverse round per
// enabled clock.
//
// Ports:
//   CLK        in   1    clock, rising edge
//   RST        in   1    asynchronous reset, active low
//   CE         in   1    clock enable; low freezes every register
//   in_valid   in   1    ct/key/tweak valid
//   in_ready   out  1    high in IDLE
//   ct         in   64   ciphertext (nibble 0 = bits [63:60])
//   key        in   128  K0 = key[127:64], K1 = key[63:0]
//   tweak      in   64   tweak T
//   out_valid  out  1    pt valid
//   out_ready  in   1    consumer accepts pt
//   pt         out  64   plaintext, held until the next block completes
//
// Build option CRAFT_DEC_RC_ROM_EN: when defined, round constants are read from
// the package table indexed by the round counter; otherwise an 8-bit register
// is loaded at accept and stepped with the backward LFSR every round.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for in_valid; tweakeys and first state loaded on accept
// RUN     | one inverse round per CE cycle, r counts 30 down to 0
// DONE    | pt valid; leaves on out_ready && CE
module craft_decrypt
  import craft_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  ct,
  input  logic [127:0] key,
  input  logic [63:0]  tweak,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  pt
);

  state_e           state_q, state_d;
  logic [63:0]      blk_q, blk_d;
  logic [3:0][63:0] tk_q, tk_d;
  logic [4:0]       r_q, r_d;
  logic [63:0]      pt_q, pt_d;

  logic [63:0]      tw_perm;
  logic [3:0][63:0] tk_new;
  logic [63:0]      tk_sel;
  logic [7:0]       rc_cur;
  logic [63:0]      round_out;
  logic             accept;

  // TK0 = K0^T, TK1 = K1^T, TK2 = K0^Q(T), TK3 = K1^Q(T); index 0 is TK0.
  assign tw_perm = q_perm(tweak);
  assign tk_new  = {key[63:0]   ^ tw_perm,
                    key[127:64] ^ tw_perm,
                    key[63:0]   ^ tweak,
                    key[127:64] ^ tweak};

  assign accept = (state_q == ST_IDLE) && in_valid && CE;
  assign tk_sel = tk_q[r_q[1:0]];

`ifdef CRAFT_DEC_RC_ROM_EN
  assign rc_cur = RC_TABLE[r_q];
`else
  logic [7:0] rc_q, rc_d;

  always_comb begin
    rc_d = rc_q;
    if (accept) begin
      rc_d = RC_TABLE[ROUND_FIRST];
    end else if ((state_q == ST_RUN) && CE) begin
      rc_d = rc_back(rc_q);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rc_q <= '0;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign rc_cur = rc_q;
`endif

  craft_inv_round u_inv_round (
    .din  (blk_q),
    .tk   (tk_sel),
    .rc   (rc_cur),
    .dout (round_out)
  );

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    tk_d      = tk_q;
    r_d       = r_q;
    pt_d      = pt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          // Undo the final (short) encryption round: ATK with TK3, ARC with
          // RC_31, then MC, which is its own inverse.
          blk_d   = mix_columns(add_rc(ct ^ tk_new[3], RC_TABLE[31]));
          tk_d    = tk_new;
          r_d     = ROUND_FIRST;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (CE) begin
          blk_d = round_out;
          if (r_q == ROUND_LAST) begin
            pt_d    = round_out;
            state_d = ST_DONE;
          end else begin
            r_d = r_q - 5'd1;
          end
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready && CE) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      tk_q    <= '0;
      r_q     <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      tk_q    <= tk_d;
      r_q     <= r_d;
      pt_q    <= pt_d;
    end
  end

  assign pt = pt_q;

endmodule
